lector_temp_serial: RTL and testbench
=====================================

Name: lector_temp_serial

Overview:
- Producer side of the temperature path. Periodically reads an 8-bit Celsius value from the serial temperature sensor over a 3-wire read-only bus (cs_n, sclk, sdata).
- Quantizes the reading into the 3-bit temperature code that the threshold comparators consume.
- Holds the code stable between conversions and flags each update with a one-cycle valid pulse.
- Code 3'b100 corresponds to 28 °C, so the existing 28 °C threshold logic works unchanged.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (>=1)
N_BITS, 8, data bits per sensor frame, MSB first
SAMPLE_PERIOD, 1000, idle clk cycles between end of one frame and start of next (>=1)
TEMP_BASE, 24, sensor value mapped to code 0
STEP_SHIFT, 0, right shift applied after offset (degrees per code step = 2^STEP_SHIFT)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  1 = run periodic conversions; 0 = stop after the current frame
sdata  input  1  serial data from sensor; sensor updates it on sclk falling edge
cs_n  output  1  sensor chip select, active low
sclk  output  1  serial clock, idles high
temp  output  3  quantized temperature code, held between updates
temp_valid  output  1  one-cycle pulse when temp is updated
busy  output  1  high while cs_n is low

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Outputs: cs_n=1, sclk=1, temp=3'b000, temp_valid=0, busy=0.
  - Internal state: FSM to IDLE, period timer cleared, shift register cleared.
  - Reset mid-frame aborts the frame immediately. No temp_valid is produced, and temp stays 0.
- FSM states: IDLE, WAIT, SETUP, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - If enable=1, go to SETUP on the next edge.
  - The first frame after reset starts without waiting SAMPLE_PERIOD.
- SETUP:
  - cs_n=0, sclk=1, held for CLK_DIV cycles.
  - Then go to SHIFT_LO with bit counter = N_BITS-1.
- SHIFT_LO: sclk=0 for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles.
  - On the clk edge where sclk goes 0->1, sdata is shifted into the LSB of the shift register, so the first captured bit ends up as the MSB.
  - At the end of the half-period: if bit counter=0, go to DONE; otherwise decrement and return to SHIFT_LO.
- Frame length: cs_n is low for exactly CLK_DIV*(1+2*N_BITS) cycles.
- DONE (1 cycle):
  - cs_n=1, sclk=1.
  - temp is loaded with the quantized value; temp_valid=1 for this single cycle.
  - Then go to WAIT.
- Latency: temp_valid is asserted in the first cycle that cs_n is high again after a frame.
- WAIT:
  - Count SAMPLE_PERIOD cycles.
  - At terminal count, go to SETUP if enable=1, otherwise go to IDLE.
- enable deasserted during SETUP, SHIFT or WAIT does not truncate a frame. The frame in progress completes and temp_valid still fires.
- Quantization: let d be the unsigned N_BITS result.
  - If d < TEMP_BASE, code = 0.
  - Otherwise q = (d - TEMP_BASE) >> STEP_SHIFT, and code = 7 if q > 7, else q[2:0].
  - Arithmetic is done at N_BITS+1 width so there is no wrap-around.
- busy equals ~cs_n.
- sclk and cs_n are driven from registers (glitch-free), not from combinational FSM decode.
- temp changes only in DONE or on reset.

Test Plan:
- CLK_DIV=2, N_BITS=8, TEMP_BASE=24, STEP_SHIFT=0; sensor model drives 0x1C -> cs_n low for 34 cycles, 8 sclk rising edges; next cycle temp=3'b100, temp_valid=1 for exactly one cycle.
- Sensor drives 0x1B (27) then 0x10 (16) on consecutive frames -> temp=3'b011 after frame 1; temp=3'b000 after frame 2 (low saturation).
- Sensor drives 0xFF -> temp=3'b111 (high saturation, no wrap). With STEP_SHIFT=1 and 0x22 (34) -> temp=3'b101.
- SAMPLE_PERIOD=10, enable held high -> successive cs_n falling edges exactly 34+1+10 cycles apart. Drop enable mid-SHIFT -> current frame completes with temp_valid, then no further cs_n activity.
- reset_n=0 during the 4th bit of a frame -> next edge: cs_n=1, sclk=1, temp=0, busy=0, no temp_valid. After release with enable=1, a fresh full frame starts.
- enable=0 from reset -> cs_n stays 1, sclk stays 1, temp stays 0 indefinitely.

Source files
------------

// File: rtl/lector_temp_serial.sv
// lector_temp_serial: periodic reader for a 3-wire read-only serial temperature
// sensor. Each frame clocks in N_BITS (MSB first), quantizes the Celsius value
// into a 3-bit code (code 4 = 28 C by default), holds it, and pulses temp_valid.
module lector_temp_serial #(
  parameter int CLK_DIV       = 4,
  parameter int N_BITS        = 8,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TEMP_BASE     = 24,
  parameter int STEP_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sdata,
  output logic       cs_n,
  output logic       sclk,
  output logic [2:0] temp,
  output logic       temp_valid,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0]  C_BIT_FIRST = BIT_W'(N_BITS - 1);
  localparam logic [N_BITS:0]   C_BASE      = (N_BITS + 1)'(TEMP_BASE);
  localparam logic [N_BITS:0]   C_CODE_MAX  = (N_BITS + 1)'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DIV_W-1:0]    r_div;
  logic [TMR_W-1:0]    r_tmr;
  logic [BIT_W-1:0]    r_bit;
  logic [N_BITS-1:0]   r_shift;
  logic                r_cs_n;
  logic                r_sclk;
  logic [2:0]          r_temp;
  logic                r_valid;

  logic                w_div_last;
  logic                w_tmr_last;
  logic                w_in_frame;
  logic                w_nxt_in_frame;
  logic                w_shift_en;
  logic                w_bit_load;
  logic                w_bit_dec;

  // Offset, scale and saturate a raw reading into the 3-bit code. The extra
  // top bit keeps the subtraction and the range compare free of wrap-around.
  function automatic logic [2:0] f_quant(input logic [N_BITS-1:0] d);
    logic [N_BITS:0] w_ext;
    logic [N_BITS:0] w_q;
    w_ext = {1'b0, d};
    if (w_ext < C_BASE) begin
      return 3'd0;
    end
    w_q = (w_ext - C_BASE) >> STEP_SHIFT;
    if (w_q > C_CODE_MAX) begin
      return 3'd7;
    end
    return w_q[2:0];
  endfunction

  assign w_div_last = (r_div == C_DIV_LAST);
  assign w_tmr_last = (r_tmr == C_TMR_LAST);
  assign w_in_frame = (r_state == S_SETUP) || (r_state == S_SHIFT_LO) ||
                      (r_state == S_SHIFT_HI);
  assign w_nxt_in_frame = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT_LO) ||
                          (w_state_nxt == S_SHIFT_HI);

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the strobes that steer the bit counter and shifter.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_bit_load  = 1'b0;
    w_bit_dec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_state_nxt = S_SHIFT_LO;
          w_bit_load  = 1'b1;
        end
      end
      S_SHIFT_LO: begin
        // sclk rises on this edge: the sensor's bit has been stable since the fall.
        if (w_div_last) begin
          w_state_nxt = S_SHIFT_HI;
          w_shift_en  = 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (w_div_last) begin
          if (r_bit == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT_LO;
            w_bit_dec   = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_tmr_last) begin
          w_state_nxt = enable ? S_SETUP : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Phase divider, period timer, bit counter, shifter and registered bus/outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_tmr   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_temp  <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_div <= (w_in_frame && !w_div_last) ? r_div + 1'b1 : '0;
      r_tmr <= ((r_state == S_WAIT) && !w_tmr_last) ? r_tmr + 1'b1 : '0;

      if (w_bit_load) begin
        r_bit <= C_BIT_FIRST;
      end else if (w_bit_dec) begin
        r_bit <= r_bit - 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= {r_shift[N_BITS-2:0], sdata};
      end

      // Bus pins follow the next state so they are glitch-free flops aligned with it.
      r_cs_n  <= !w_nxt_in_frame;
      r_sclk  <= (w_state_nxt != S_SHIFT_LO);
      r_valid <= (w_state_nxt == S_DONE);

      if (w_state_nxt == S_DONE) begin
        r_temp <= f_quant(r_shift);
      end
    end
  end

  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign temp       = r_temp;
  assign temp_valid = r_valid;
  assign busy       = ~r_cs_n;

endmodule

// File: tb/tb_lector_temp_serial.sv
// Bench for lector_temp_serial: two instances (STEP_SHIFT 0 and 1) run in lockstep
// against one behavioural sensor; vectors table plus reset/enable sequences.
module tb_lector_temp_serial;

  localparam int CLK_DIV       = 2;
  localparam int N_BITS        = 8;
  localparam int SAMPLE_PERIOD = 10;
  localparam int FRAME_LOW     = CLK_DIV * (1 + 2 * N_BITS);
  localparam int GAP           = FRAME_LOW + 1 + SAMPLE_PERIOD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       sdata = 1'b0;
  logic       cs_n, sclk, temp_valid, busy;
  logic [2:0] temp;
  logic       cs_n1, sclk1, temp_valid1, busy1;
  logic [2:0] temp1;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_fall = 0;
  logic [7:0] word = 8'h00;
  int         idx = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] e0;
    logic [2:0] e1;
  } vec_t;

  vec_t vecs[10];

  lector_temp_serial #(
    .CLK_DIV(CLK_DIV), .N_BITS(N_BITS), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .TEMP_BASE(24), .STEP_SHIFT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sdata(sdata),
    .cs_n(cs_n), .sclk(sclk), .temp(temp), .temp_valid(temp_valid), .busy(busy)
  );

  lector_temp_serial #(
    .CLK_DIV(CLK_DIV), .N_BITS(N_BITS), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .TEMP_BASE(24), .STEP_SHIFT(1)
  ) dut_s1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sdata(sdata),
    .cs_n(cs_n1), .sclk(sclk1), .temp(temp1), .temp_valid(temp_valid1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: restart on cs_n fall, present next bit (MSB first) on each sclk fall.
  always @(negedge cs_n or negedge sclk) begin
    if (!cs_n && !sclk) begin
      if (idx > 0) begin
        idx = idx - 1;
        sdata = word[idx];
      end
    end else if (!cs_n) begin
      idx = N_BITS;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [2:0] e0, input logic [2:0] e1,
                           input int drop_at, input bit chk_gap, input string tag);
    int   t;
    int   low;
    int   rises;
    logic prev;
    logic vbad;
    word = d;
    t = 0;
    while (cs_n !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " start"}, {31'd0, cs_n}, 32'd0);
    if (cs_n !== 1'b0) return;
    if (chk_gap) chk({tag, " gap"}, cyc - last_fall, GAP);
    last_fall = cyc;
    low = 0;
    rises = 0;
    prev = sclk;
    vbad = 1'b0;
    while (cs_n === 1'b0 && low < 200) begin
      low++;
      if (low == drop_at) enable = 1'b0;
      @(negedge clk);
      if (cs_n === 1'b0) begin
        if (sclk === 1'b1 && prev === 1'b0) rises++;
        if (temp_valid !== 1'b0) vbad = 1'b1;
      end
      prev = sclk;
    end
    chk({tag, " cs_low_cycles"}, low, FRAME_LOW);
    chk({tag, " sclk_rises"}, rises, N_BITS);
    chk({tag, " valid_in_frame"}, {31'd0, vbad}, 32'd0);
    chk({tag, " valid"}, {31'd0, temp_valid}, 32'd1);
    chk({tag, " temp"}, {29'd0, temp}, {29'd0, e0});
    chk({tag, " temp_s1"}, {29'd0, temp1}, {29'd0, e1});
    @(negedge clk);
    chk({tag, " valid_pulse_end"}, {31'd0, temp_valid}, 32'd0);
    chk({tag, " temp_hold"}, {29'd0, temp}, {29'd0, e0});
  endtask

  initial begin
    int   t;
    int   rises;
    logic prev;
    logic bad;

    vecs[0] = '{8'h1C, 3'd4, 3'd2};
    vecs[1] = '{8'h1B, 3'd3, 3'd1};
    vecs[2] = '{8'h10, 3'd0, 3'd0};
    vecs[3] = '{8'hFF, 3'd7, 3'd7};
    vecs[4] = '{8'h22, 3'd7, 3'd5};
    vecs[5] = '{8'h18, 3'd0, 3'd0};
    vecs[6] = '{8'h1F, 3'd7, 3'd3};
    vecs[7] = '{8'h20, 3'd7, 3'd4};
    vecs[8] = '{8'h19, 3'd1, 3'd0};
    vecs[9] = '{8'h00, 3'd0, 3'd0};

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, cs_n, sclk, temp, temp_valid, busy}, 32'b1100000);

    // enable low out of reset: bus stays idle
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || temp !== 3'd0 || temp_valid !== 1'b0) bad = 1'b1;
    end
    chk("idle_no_enable", {31'd0, bad}, 32'd0);

    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].d, vecs[i].e0, vecs[i].e1, -1, (i > 0), $sformatf("vec%0d", i));
    end

    // drop enable mid-shift: frame completes, then the bus goes quiet
    run_frame(8'h1D, 3'd5, 3'd2, 10, 1'b1, "drop");
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || temp_valid !== 1'b0) bad = 1'b1;
    end
    chk("no_frame_after_drop", {31'd0, bad}, 32'd0);
    chk("temp_held_after_drop", {29'd0, temp}, 32'd5);

    // reset during the 4th bit aborts the frame
    enable = 1'b1;
    word = 8'hFF;
    t = 0;
    while (cs_n !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_frame_start", {31'd0, cs_n}, 32'd0);
    rises = 0;
    prev = sclk;
    t = 0;
    while (!(rises == 3 && sclk === 1'b0) && t < 200) begin
      @(negedge clk);
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      t++;
    end
    chk("rst_at_bit4", rises, 32'd3);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {25'd0, cs_n, sclk, temp, temp_valid, busy}, 32'b1100000);
    @(negedge clk);
    chk("rst_mid_hold", {25'd0, cs_n, sclk, temp, temp_valid, busy}, 32'b1100000);
    chk("rst_mid_temp_s1", {29'd0, temp1}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_cs", {31'd0, cs_n}, 32'd0);
    run_frame(8'h1C, 3'd4, 3'd2, -1, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
